bmp_stream_writer: RTL and testbench
====================================

Name: bmp_stream_writer

Overview:
- Accepts a raw frame as a top-down byte stream: rows top to bottom, pixels left to right, bytes in R,G,B order per pixel.
- Buffers the frame, then emits a complete 24-bit BMP file byte stream:
  - 54-byte header first;
  - pixel rows bottom-up, bytes in B,G,R order per pixel, each row zero-padded to a 4-byte multiple.
- Converse of the BMP-ingest pixel path. Feeds a byte-serial sink (UART TX / storage writer) that may apply backpressure.

Parameters:
- scanline_width, 320, pixels per row (>=1).
- image_height, 256, rows per frame (>=1).
- Derived constants, not overridable:
  - row_bytes = scanline_width*3
  - pad_bytes = (4 - row_bytes%4)%4
  - image_bytes = (row_bytes+pad_bytes)*image_height
  - file_bytes = 54 + image_bytes

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  input byte strobe; i_data is written when ena && i_ready.
- i_data  input  8  frame byte, top-down RGB order.
- i_ready  output  1  high only in LOAD.
- o_data  output  8  BMP stream byte; stable while o_valid && !o_ready.
- o_valid  output  1  o_data holds a valid byte.
- o_ready  input  1  sink accepts; a transfer occurs on a clock edge with o_valid && o_ready.
- d_ok  output  1  whole file emitted; sticky until rst.
- led  output  16  debug:
  - [7:0] = i_data in LOAD, o_data otherwise;
  - [13:8] = byte counter[5:0];
  - [14] = d_ok;
  - [15] = o_valid.

Behaviour:
- Reset (async, rst=1), all take effect immediately:
  - state=LOAD; counters=0;
  - o_valid=0, o_data=0, d_ok=0, i_ready=1.
- Frame buffer contents are not reset.
- States:
  - LOAD -> HEADER when the row_bytes*image_height-th byte is written.
  - HEADER -> PIXELS after byte 53 transfers.
  - PIXELS -> DONE after the last pad/pixel byte of the top row transfers.
  - DONE holds until rst.
- LOAD:
  - each ena cycle stores i_data at address = in_count, then in_count+1;
  - ena while i_ready=0 is ignored, with no side effects.
- Output handshake:
  - the next byte is presented the cycle after a transfer (one memory-read latency), so sustained throughput is 1 byte per 2 clocks;
  - o_valid is never deasserted without a transfer, except on reset;
  - o_ready is ignored while o_valid=0.
- Header bytes, little-endian multi-byte fields, by index:
  - 0-1 'B','M' (0x42,0x4D)
  - 2-5 file_bytes
  - 6-9 0
  - 10-13 54
  - 14-17 40
  - 18-21 scanline_width
  - 22-25 image_height (positive, bottom-up)
  - 26-27 1
  - 28-29 24
  - 30-33 0
  - 34-37 image_bytes
  - 38-41 2835
  - 42-45 2835
  - 46-53 0
- PIXELS:
  - row r runs from image_height-1 down to 0; pixel p from 0 up to scanline_width-1;
  - emit buf[r*row_bytes+p*3+2], then +1, then +0;
  - after the last pixel of a row, emit pad_bytes zero bytes with no memory read;
  - with pad_bytes=0, go directly to the next row.
- DONE:
  - d_ok=1 in the cycle after the final transfer;
  - o_valid=0; i_ready=0.
- Widths:
  - address counter is $clog2(row_bytes*image_height) bits;
  - header fields are computed at elaboration as 32-bit constants.
- Reset mid-LOAD or mid-emit aborts the frame. No partial-frame continuation.

Decomposition:
- Shared package bmp_pkg holds:
  - BMP_HDR_BYTES=54, BMP_DIB_SIZE=40, BMP_BPP=24, BMP_PPM=2835;
  - state enum {LOAD,HEADER,PIXELS,DONE};
  - function bmp_hdr_byte(idx,width,height) returning the header byte.
- One sub-module: bmp_frame_ram, a single-port synchronous RAM of 8 x (row_bytes*image_height) with registered read. Write is used in LOAD, read in PIXELS.

Test Plan:
- Params width=2, height=2, load bytes 0x01..0x0C with o_ready=1 -> header bytes 2-5 = 46 00 00 00 (file 70), 34-37 = 10 00 00 00; pixel stream = 09 08 07 0C 0B 0A 00 00 03 02 01 06 05 04 00 00; d_ok=1 after 70 transfers.
- Width=4, height=1 (pad 0), bytes 0x10..0x1B -> stream after header = 12 11 10 15 14 13 18 17 16 1B 1A 19, no pad; file_bytes=66.
- Random o_ready (50%) on the 2x2 case -> byte sequence identical to the first test; o_data never changes while o_valid && !o_ready.
- ena asserted during HEADER/PIXELS with random i_data -> output unchanged; no buffer corruption.
- Assert rst mid-PIXELS -> o_valid=0, d_ok=0, i_ready=1 in the same cycle; a reload then yields the full correct file again starting with 0x42.
- Default 320x256 -> header bytes 18-19 = 40 01, 22-23 = 00 01, file_bytes=245814; first pixel byte emitted = buf[255*960+2].

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared BMP constants, FSM state type and the 54-byte header generator.
// Header fields are little-endian; all sizes derive from width/height.
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_DIB_SIZE  = 40;
    localparam int BMP_BPP       = 24;
    localparam int BMP_PPM       = 2835;

    typedef enum logic [1:0] {
        LOAD,
        HEADER,
        PIXELS,
        DONE
    } state_t;

    function automatic logic [7:0] bmp_hdr_byte(
        input int idx,
        input int width,
        input int height
    );
        int          row_b;
        int          pad_b;
        int          img_b;
        int          base;
        logic [31:0] f;
        row_b = width * 3;
        pad_b = (4 - row_b % 4) % 4;
        img_b = (row_b + pad_b) * height;
        if (idx < 2) begin
            f = 32'h0000_4D42; base = 0;
        end else if (idx < 6) begin
            f = 32'(BMP_HDR_BYTES + img_b); base = 2;
        end else if (idx < 10) begin
            f = 32'd0; base = 6;
        end else if (idx < 14) begin
            f = 32'(BMP_HDR_BYTES); base = 10;
        end else if (idx < 18) begin
            f = 32'(BMP_DIB_SIZE); base = 14;
        end else if (idx < 22) begin
            f = 32'(width); base = 18;
        end else if (idx < 26) begin
            f = 32'(height); base = 22;
        end else if (idx < 28) begin
            f = 32'd1; base = 26;
        end else if (idx < 30) begin
            f = 32'(BMP_BPP); base = 28;
        end else if (idx < 34) begin
            f = 32'd0; base = 30;
        end else if (idx < 38) begin
            f = 32'(img_b); base = 34;
        end else if (idx < 42) begin
            f = 32'(BMP_PPM); base = 38;
        end else if (idx < 46) begin
            f = 32'(BMP_PPM); base = 42;
        end else begin
            f = 32'd0; base = 46;
        end
        return 8'(f >> (8 * (idx - base)));
    endfunction

endpackage

// File: rtl/bmp_frame_ram.sv
// Single-port frame buffer, registered read, no reset on contents.
// Write wins over read on the shared address port.
module bmp_frame_ram
    import bmp_pkg::*;
#(
    parameter int depth = 12,
    parameter int aw    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [aw-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    q
);

    logic [7:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// Buffers a top-down RGB frame, then streams it out as a 24-bit BMP file
// (header, bottom-up BGR rows, 4-byte row padding) over a valid/ready port.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int scanline_width = 320,
    parameter int image_height   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [7:0]  i_data,
    output logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        d_ok,
    output logic [15:0] led
);

    localparam int ROW_BYTES   = scanline_width * 3;
    localparam int PAD_BYTES   = (4 - ROW_BYTES % 4) % 4;
    localparam int IMAGE_BYTES = (ROW_BYTES + PAD_BYTES) * image_height;
    localparam int FILE_BYTES  = BMP_HDR_BYTES + IMAGE_BYTES;
    localparam int TOTAL       = ROW_BYTES * image_height;
    localparam int AW          = $clog2(TOTAL);
    localparam int CW          = $clog2(FILE_BYTES + 1);
    localparam int RW          = $clog2(image_height + 1);
    localparam int PW          = $clog2(scanline_width + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] row, row_n;
    logic [PW-1:0] pix, pix_n;
    logic [1:0]    comp, comp_n;
    logic [1:0]    padn, padn_n;
    logic          in_pad, pad_n;
    logic          pend_pad;
    logic          row_end;
    logic          we;
    logic          re;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_q;

    assign i_ready = (state == LOAD);
    assign we      = ena && i_ready;
    assign re      = (state == HEADER || state == PIXELS) && !in_pad;
    assign led     = {o_valid, d_ok, cnt[5:0],
                      (state == LOAD) ? i_data : o_data};

    // Read position runs one byte ahead of the presented byte so the
    // RAM latency hides inside the idle cycle after each transfer.
    assign ram_addr = (state == LOAD) ? cnt[AW-1:0]
                    : AW'(32'(row) * ROW_BYTES + 32'(pix) * 3
                          + 2 - 32'(comp));

    always_comb begin
        row_n   = row;
        pix_n   = pix;
        comp_n  = comp;
        padn_n  = padn;
        pad_n   = in_pad;
        row_end = 1'b0;
        if (in_pad) begin
            if (padn == 2'(PAD_BYTES - 1)) begin
                padn_n  = 2'd0;
                pad_n   = 1'b0;
                row_end = 1'b1;
            end else begin
                padn_n = padn + 2'd1;
            end
        end else if (comp != 2'd2) begin
            comp_n = comp + 2'd1;
        end else begin
            comp_n = 2'd0;
            if (pix != PW'(scanline_width - 1)) begin
                pix_n = pix + PW'(1);
            end else begin
                pix_n = '0;
                if (PAD_BYTES != 0) pad_n = 1'b1;
                else row_end = 1'b1;
            end
        end
        if (row_end && row != '0) row_n = row - RW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            cnt      <= '0;
            row      <= RW'(image_height - 1);
            pix      <= '0;
            comp     <= '0;
            padn     <= '0;
            in_pad   <= 1'b0;
            pend_pad <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= 8'd0;
            d_ok     <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (we) begin
                        if (cnt == CW'(TOTAL - 1)) begin
                            state <= HEADER;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HEADER: begin
                    if (!o_valid) begin
                        o_data  <= bmp_hdr_byte(int'(cnt),
                                                scanline_width,
                                                image_height);
                        o_valid <= 1'b1;
                    end else if (o_ready) begin
                        o_valid <= 1'b0;
                        cnt     <= cnt + CW'(1);
                        if (cnt == CW'(BMP_HDR_BYTES - 1)) begin
                            state    <= PIXELS;
                            pend_pad <= in_pad;
                            row      <= row_n;
                            pix      <= pix_n;
                            comp     <= comp_n;
                            padn     <= padn_n;
                            in_pad   <= pad_n;
                        end
                    end
                end
                PIXELS: begin
                    if (!o_valid) begin
                        o_data  <= pend_pad ? 8'd0 : ram_q;
                        o_valid <= 1'b1;
                    end else if (o_ready) begin
                        o_valid <= 1'b0;
                        cnt     <= cnt + CW'(1);
                        if (cnt == CW'(FILE_BYTES - 1)) begin
                            state <= DONE;
                            d_ok  <= 1'b1;
                        end else begin
                            pend_pad <= in_pad;
                            row      <= row_n;
                            pix      <= pix_n;
                            comp     <= comp_n;
                            padn     <= padn_n;
                            in_pad   <= pad_n;
                        end
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end

    bmp_frame_ram #(
        .depth(TOTAL),
        .aw   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .re   (re),
        .addr (ram_addr),
        .wdata(i_data),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: three geometries against a queue-based
// model of the BMP file, random backpressure, stray writes and aborts.
module tb_bmp_stream_writer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ena_a  [3];
    logic [7:0]  idat_a [3];
    logic        ordy_a [3];
    logic        ird_a  [3];
    logic [7:0]  od_a   [3];
    logic        ov_a   [3];
    logic        dok_a  [3];
    logic [15:0] led_a  [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];
    logic [7:0] exp_q[$];

    bmp_stream_writer #(.scanline_width(2), .image_height(2)) dut0 (
        .clk(clk), .rst(rst), .ena(ena_a[0]), .i_data(idat_a[0]),
        .i_ready(ird_a[0]), .o_data(od_a[0]), .o_valid(ov_a[0]),
        .o_ready(ordy_a[0]), .d_ok(dok_a[0]), .led(led_a[0]));

    bmp_stream_writer #(.scanline_width(4), .image_height(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena_a[1]), .i_data(idat_a[1]),
        .i_ready(ird_a[1]), .o_data(od_a[1]), .o_valid(ov_a[1]),
        .o_ready(ordy_a[1]), .d_ok(dok_a[1]), .led(led_a[1]));

    bmp_stream_writer #(.scanline_width(3), .image_height(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena_a[2]), .i_data(idat_a[2]),
        .i_ready(ird_a[2]), .o_data(od_a[2]), .o_valid(ov_a[2]),
        .o_ready(ordy_a[2]), .d_ok(dok_a[2]), .led(led_a[2]));

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_le(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endfunction

    // Whole expected file from the format rules; pixels only if frm is full.
    function automatic void build_model(input int w, input int h);
        int rb, pb, ib;
        rb = w * 3;
        pb = (4 - rb % 4) % 4;
        ib = (rb + pb) * h;
        exp_q.delete();
        push_le(32'h4D42, 2); push_le(54 + ib, 4); push_le(0, 4);
        push_le(54, 4);       push_le(40, 4);      push_le(w, 4);
        push_le(h, 4);        push_le(1, 2);       push_le(24, 2);
        push_le(0, 4);        push_le(ib, 4);      push_le(2835, 4);
        push_le(2835, 4);     push_le(0, 4);       push_le(0, 4);
        if (frm.size() >= rb * h) begin
            for (int r = h - 1; r >= 0; r--) begin
                for (int p = 0; p < w; p++)
                    for (int c = 2; c >= 0; c--)
                        exp_q.push_back(frm[r * rb + p * 3 + c]);
                for (int z = 0; z < pb; z++) exp_q.push_back(8'h00);
            end
        end
    endfunction

    task automatic idle_all();
        for (int j = 0; j < 3; j++) begin
            ena_a[j]  = 1'b0;
            idat_a[j] = 8'h00;
            ordy_a[j] = 1'b0;
        end
    endtask

    task automatic run(input int k, input int w, input int h,
                       input bit rnd_rdy, input bit inject,
                       input bit gaps, input int abort_at);
        int n, i, idx, cyc, last_t;
        bit pv, pr, rdy;
        logic [7:0] pd;
        n = w * h * 3;
        build_model(w, h);
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        #1;
        chk("rst_ird", ird_a[k], 1);
        chk("rst_ov", ov_a[k], 0);
        chk("rst_dok", dok_a[k], 0);
        chk("rst_od", od_a[k], 0);
        @(negedge clk);
        rst = 1'b0;
        i = 0;
        while (i < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                ena_a[k]  = 1'b0;
                idat_a[k] = 8'($urandom);
            end else begin
                ena_a[k]  = 1'b1;
                idat_a[k] = frm[i];
                i++;
            end
            #1;
            chk("ld_ird", ird_a[k], 1);
            chk("ld_led", led_a[k][7:0], idat_a[k]);
            @(negedge clk);
        end
        ena_a[k] = 1'b0;
        chk("hdr_ird", ird_a[k], 0);
        idx = 0; cyc = 0; last_t = -1; pv = 0; pr = 0; pd = 8'h00;
        while (idx < exp_q.size() && cyc < 20000) begin
            if (pv && !pr) begin
                chk("hold_v", ov_a[k], 1);
                chk("hold_d", od_a[k], pd);
            end
            chk("dok_early", dok_a[k], 0);
            rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            ordy_a[k] = rdy;
            if (inject) begin
                ena_a[k]  = 1'($urandom_range(0, 1));
                idat_a[k] = 8'($urandom);
            end
            if (ov_a[k] && rdy) begin
                chk($sformatf("byte%0d", idx), od_a[k], exp_q[idx]);
                chk("led_out", {led_a[k][15], led_a[k][7:0]},
                    {1'b1, exp_q[idx]});
                if (!rnd_rdy && last_t >= 0) chk("gap", cyc - last_t, 2);
                last_t = cyc;
                idx++;
            end
            pv = ov_a[k]; pr = rdy; pd = od_a[k];
            if (abort_at > 0 && idx == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_ov", ov_a[k], 0);
                chk("abort_dok", dok_a[k], 0);
                chk("abort_ird", ird_a[k], 1);
                @(negedge clk);
                idle_all();
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        chk("timeout", idx, exp_q.size());
        chk("done_dok", dok_a[k], 1);
        chk("done_ov", ov_a[k], 0);
        chk("done_ird", ird_a[k], 0);
        ordy_a[k] = 1'b1;
        ena_a[k]  = 1'b1;
        repeat (3) @(negedge clk);
        chk("sticky_dok", dok_a[k], 1);
        chk("sticky_ov", ov_a[k], 0);
        idle_all();
    endtask

    initial begin
        logic [7:0] lit22 [16];
        logic [7:0] lit41 [12];
        lit22 = '{8'h09, 8'h08, 8'h07, 8'h0C, 8'h0B, 8'h0A, 8'h00, 8'h00,
                  8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04, 8'h00, 8'h00};
        lit41 = '{8'h12, 8'h11, 8'h10, 8'h15, 8'h14, 8'h13,
                  8'h18, 8'h17, 8'h16, 8'h1B, 8'h1A, 8'h19};
        idle_all();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        frm.delete();
        build_model(320, 256);
        chk("m_def_w", {exp_q[19], exp_q[18]}, 16'h0140);
        chk("m_def_h", {exp_q[23], exp_q[22]}, 16'h0100);
        chk("m_def_file", {exp_q[5], exp_q[4], exp_q[3], exp_q[2]}, 245814);

        for (int b = 1; b <= 12; b++) frm.push_back(8'(b));
        build_model(2, 2);
        chk("m22_size", exp_q.size(), 70);
        chk("m22_file", {exp_q[5], exp_q[4], exp_q[3], exp_q[2]}, 70);
        chk("m22_img", {exp_q[37], exp_q[36], exp_q[35], exp_q[34]}, 16);
        for (int j = 0; j < 16; j++) chk("m22_pix", exp_q[54 + j], lit22[j]);
        run(0, 2, 2, 0, 0, 0, 0);
        run(0, 2, 2, 1, 1, 0, 0);

        frm.delete();
        for (int b = 16; b < 28; b++) frm.push_back(8'(b));
        build_model(4, 1);
        chk("m41_size", exp_q.size(), 66);
        for (int j = 0; j < 12; j++) chk("m41_pix", exp_q[54 + j], lit41[j]);
        run(1, 4, 1, 0, 0, 0, 0);

        frm.delete();
        for (int b = 0; b < 12; b++) frm.push_back(8'($urandom));
        run(0, 2, 2, 0, 1, 0, 60);
        run(0, 2, 2, 1, 1, 1, 0);

        frm.delete();
        for (int b = 0; b < 18; b++) frm.push_back(8'($urandom));
        run(2, 3, 2, 1, 1, 1, 0);
        run(2, 3, 2, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
